bp_io_to_axil_master: RTL and testbench

// Consumes outgoing uncached I/O commands (io_cmd) from the unicore and issues them as AXI4-Lite master transactions.

---
 rtl/bp_io_to_axil_master_if.sv | 44 ++++
 rtl/bp_io_to_axil_master.sv | 169 ++++++++++++++++
 tb/tb_bp_io_to_axil_master.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_io_to_axil_master_if.sv
// Bundles the uncached I/O command/response ports and the AXI4-Lite master channels
// of bp_io_to_axil_master. master = bridge side, slave = unicore/interconnect side.
interface bp_io_to_axil_master_if #(
  parameter int paddr_width_p    = 40,
  parameter int data_width_p     = 64,
  parameter int axi_addr_width_p = 32,
  parameter int axi_data_width_p = 32
);
  localparam int msg_width_lp = data_width_p + 3 + paddr_width_p + 4;

  logic [msg_width_lp-1:0]       io_cmd, io_resp;
  logic                          io_cmd_v, io_cmd_ready_and, io_resp_v, io_resp_yumi;

  logic [axi_addr_width_p-1:0]   m_axil_awaddr, m_axil_araddr;
  logic [2:0]                    m_axil_awprot, m_axil_arprot;
  logic                          m_axil_awvalid, m_axil_awready;
  logic [axi_data_width_p-1:0]   m_axil_wdata, m_axil_rdata;
  logic [axi_data_width_p/8-1:0] m_axil_wstrb;
  logic                          m_axil_wvalid, m_axil_wready;
  logic [1:0]                    m_axil_bresp, m_axil_rresp;
  logic                          m_axil_bvalid, m_axil_bready;
  logic                          m_axil_arvalid, m_axil_arready;
  logic                          m_axil_rvalid, m_axil_rready;

  modport master (
    input  io_cmd, io_cmd_v, io_resp_yumi,
    output io_cmd_ready_and, io_resp, io_resp_v,
    output m_axil_awaddr, m_axil_awprot, m_axil_awvalid, input m_axil_awready,
    output m_axil_wdata, m_axil_wstrb, m_axil_wvalid, input m_axil_wready,
    input  m_axil_bresp, m_axil_bvalid, output m_axil_bready,
    output m_axil_araddr, m_axil_arprot, m_axil_arvalid, input m_axil_arready,
    input  m_axil_rdata, m_axil_rresp, m_axil_rvalid, output m_axil_rready
  );

  modport slave (
    output io_cmd, io_cmd_v, io_resp_yumi,
    input  io_cmd_ready_and, io_resp, io_resp_v,
    input  m_axil_awaddr, m_axil_awprot, m_axil_awvalid, output m_axil_awready,
    input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid, output m_axil_wready,
    output m_axil_bresp, m_axil_bvalid, input m_axil_bready,
    input  m_axil_araddr, m_axil_arprot, m_axil_arvalid, output m_axil_arready,
    output m_axil_rdata, m_axil_rresp, m_axil_rvalid, input m_axil_rready
  );
endinterface

// File: rtl/bp_io_to_axil_master.sv
// Bridges unicore uncached I/O commands onto an AXI4-Lite master port, one command in flight.
// 8-byte accesses become two 32-bit beats, low word first; read data returns right-justified.
module bp_io_to_axil_master #(
  parameter int paddr_width_p    = 40,
  parameter int data_width_p     = 64,
  parameter int axi_addr_width_p = 32,
  parameter int axi_data_width_p = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  bp_io_to_axil_master_if.master io,
  output logic                  error_o
);
  localparam logic [3:0] e_bedrock_mem_uc_rd = 4'd2;
  localparam logic [3:0] e_bedrock_mem_uc_wr = 4'd3;

  localparam logic [2:0] e_ready = 3'd0;
  localparam logic [2:0] e_write = 3'd1;
  localparam logic [2:0] e_bresp = 3'd2;
  localparam logic [2:0] e_read  = 3'd3;
  localparam logic [2:0] e_rdata = 3'd4;
  localparam logic [2:0] e_resp  = 3'd5;

  typedef struct packed {
    logic [2:0]               size;
    logic [paddr_width_p-1:0] addr;
    logic [3:0]               msg_type;
  } hdr_s;

  typedef struct packed {
    logic [data_width_p-1:0] data;
    hdr_s                    hdr;
  } msg_s;

  if (axi_data_width_p != 32) begin : g_bad_data_width
    $error("bp_io_to_axil_master supports only axi_data_width_p == 32");
  end

  logic [2:0]  state_q, state_d;
  hdr_s        hdr_q, hdr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        beat_q, beat_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        error_q, error_d;

  msg_s        cmd;
  logic        two_beat, last_beat;
  logic [1:0]  off;
  logic [31:0] wword, rshift, rword;
  logic [3:0]  wstrb;

  assign cmd       = msg_s'(io.io_cmd);
  assign two_beat  = (hdr_q.size == 3'd3);
  assign last_beat = ~two_beat | beat_q;
  assign off       = hdr_q.addr[1:0];

  // Narrow writes are byte-replicated across the word and selected by strobes.
  always_comb begin
    case (hdr_q.size)
      3'd0:    begin wword = {4{wdata_q[7:0]}};  wstrb = 4'b0001 << off; end
      3'd1:    begin wword = {2{wdata_q[15:0]}}; wstrb = 4'b0011 << off; end
      3'd2:    begin wword = wdata_q[31:0];      wstrb = 4'hF;           end
      default: begin wword = beat_q ? wdata_q[63:32] : wdata_q[31:0]; wstrb = 4'hF; end
    endcase
  end

  always_comb begin
    rshift = io.m_axil_rdata >> {off, 3'b000};
    case (hdr_q.size)
      3'd0:    rword = {24'h0, rshift[7:0]};
      3'd1:    rword = {16'h0, rshift[15:0]};
      default: rword = rshift;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    beat_d    = beat_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    error_d   = error_q;
    case (state_q)
      e_ready: if (io.io_cmd_v && io.io_cmd_ready_and) begin
        hdr_d     = cmd.hdr;
        wdata_d   = cmd.data;
        rdata_d   = '0;
        beat_d    = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (cmd.hdr.size > 3'd3) begin
          error_d = 1'b1;
          state_d = e_resp;
        end else if (cmd.hdr.msg_type == e_bedrock_mem_uc_wr) state_d = e_write;
        else if (cmd.hdr.msg_type == e_bedrock_mem_uc_rd)     state_d = e_read;
        else                                                   state_d = e_resp;
      end
      e_write: begin
        aw_done_d = aw_done_q | io.m_axil_awready;
        w_done_d  = w_done_q  | io.m_axil_wready;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = e_bresp;
        end
      end
      e_bresp: if (io.m_axil_bvalid) begin
        error_d = error_q | (io.m_axil_bresp != 2'b00);
        beat_d  = 1'b1;
        state_d = last_beat ? e_resp : e_write;
      end
      e_read: if (io.m_axil_arready) state_d = e_rdata;
      e_rdata: if (io.m_axil_rvalid) begin
        error_d = error_q | (io.m_axil_rresp != 2'b00);
        if (beat_q) rdata_d[63:32] = rword;
        else        rdata_d[31:0]  = rword;
        beat_d  = 1'b1;
        state_d = last_beat ? e_resp : e_read;
      end
      e_resp: if (io.io_resp_yumi) state_d = e_ready;
      default: state_d = e_ready;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= e_ready;
      hdr_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      beat_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      beat_q    <= beat_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      error_q   <= error_d;
    end
  end

  // Both addresses share the beat-advanced word address; valids are pure state decodes.
  assign io.m_axil_awaddr  = {hdr_q.addr[axi_addr_width_p-1:2], 2'b00}
                           + {{(axi_addr_width_p-3){1'b0}}, beat_q, 2'b00};
  assign io.m_axil_araddr  = io.m_axil_awaddr;
  assign io.m_axil_awprot  = 3'b000;
  assign io.m_axil_arprot  = 3'b000;
  assign io.m_axil_awvalid = (state_q == e_write) & ~aw_done_q;
  assign io.m_axil_wvalid  = (state_q == e_write) & ~w_done_q;
  assign io.m_axil_wdata   = wword;
  assign io.m_axil_wstrb   = wstrb;
  assign io.m_axil_bready  = (state_q == e_bresp);
  assign io.m_axil_arvalid = (state_q == e_read);
  assign io.m_axil_rready  = (state_q == e_rdata);

  assign io.io_cmd_ready_and = (state_q == e_ready) & ~reset_i;
  assign io.io_resp_v        = (state_q == e_resp);
  assign io.io_resp          = {rdata_q, hdr_q};
  assign error_o             = error_q;
endmodule

// File: tb/tb_bp_io_to_axil_master.sv
// Randomized scoreboard bench for bp_io_to_axil_master: a byte-level memory model predicts
// every AXI beat and io_resp; a reactive AXI-Lite slave and a response monitor do the checking.
`timescale 1ns/1ps
module tb_bp_io_to_axil_master;
  localparam int PADDR = 40;
  localparam logic [3:0] UC_RD = 4'd2;
  localparam logic [3:0] UC_WR = 4'd3;

  typedef struct packed {
    logic [63:0]      data;
    logic [2:0]       size;
    logic [PADDR-1:0] addr;
    logic [3:0]       msg_type;
  } msg_s;

  typedef struct packed {
    msg_s msg;
    logic err;
  } resp_exp_s;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic error_o;
  int   errors = 0;
  int   checks = 0;

  bp_io_to_axil_master_if #(.paddr_width_p(PADDR)) bus ();
  bp_io_to_axil_master #(.paddr_width_p(PADDR)) dut (
    .clk_i(clk), .reset_i(reset_i), .io(bus.master), .error_o(error_o));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // ---------------- reference model ----------------
  bit [31:0]  ref_mem [bit [31:0]];
  bit [31:0]  slv_mem [bit [31:0]];
  logic [31:0] exp_aw[$];
  logic [31:0] exp_ar[$];
  logic [35:0] exp_w[$];
  resp_exp_s   exp_resp[$];
  bit          exp_err;

  function automatic bit [31:0] init_word(bit [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit [1:0] slv_resp(bit [31:0] a);
    return (a[31:28] == 4'hE) ? 2'b10 : (a[31:28] == 4'hF) ? 2'b11 : 2'b00;
  endfunction

  function automatic bit [31:0] ref_rd(bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic bit [31:0] slv_rd(bit [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
  endfunction

  task automatic model_cmd(input msg_s m);
    resp_exp_s e;
    int        n, nb, off, idx;
    bit [31:0] base, a, w, d32;
    bit [3:0]  strb;
    bit [63:0] rd;
    rd   = '0;
    off  = int'(m.addr[1:0]);
    base = {m.addr[31:2], 2'b00};
    if (m.size > 3'd3) exp_err = 1'b1;
    else begin
      n  = 1 << m.size;
      nb = (n == 8) ? 2 : 1;
      for (int b = 0; b < nb; b++) begin
        a = base + 32'(4 * b);
        if (slv_resp(a) != 2'b00) exp_err = 1'b1;
        if (m.msg_type == UC_WR) begin
          w = ref_rd(a);
          for (int i = 0; i < 4; i++) begin
            idx = (n >= 4) ? (4 * b + i) : (i % n);
            d32[8*i +: 8] = m.data[8*idx +: 8];
            strb[i] = (n >= 4) || (i >= off && i < off + n);
            if (strb[i]) w[8*i +: 8] = d32[8*i +: 8];
          end
          ref_mem[a] = w;
          exp_aw.push_back(a);
          exp_w.push_back({d32, strb});
        end else begin
          exp_ar.push_back(a);
          w = ref_rd(a) >> (8 * off);
          if (n < 4) w = w & ((32'h1 << (8 * n)) - 32'h1);
          rd[32*b +: 32] = w;
        end
      end
    end
    e.msg      = m;
    e.msg.data = (m.msg_type == UC_RD && m.size <= 3'd3) ? rd : 64'h0;
    e.err      = exp_err;
    exp_resp.push_back(e);
  endtask

  // ---------------- AXI-Lite slave ----------------
  int          rdy_pct = 100;
  bit          b_hold  = 1'b0;
  logic [31:0] got_aw[$];
  logic [35:0] got_w[$];
  logic [31:0] got_ar[$];
  logic [1:0]  pend_b[$];
  logic [35:0] last_w;

  initial begin
    bit b_fire, r_fire, aw_wait, w_wait, ar_wait;
    bit [31:0] a, m;
    bit [35:0] wd;
    b_fire = 0; r_fire = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
    bus.m_axil_awready = 0; bus.m_axil_wready = 0; bus.m_axil_arready = 0;
    bus.m_axil_bvalid = 0; bus.m_axil_bresp = 0;
    bus.m_axil_rvalid = 0; bus.m_axil_rresp = 0; bus.m_axil_rdata = 0;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        bus.m_axil_awready = 0; bus.m_axil_wready = 0; bus.m_axil_arready = 0;
        bus.m_axil_bvalid = 0; bus.m_axil_rvalid = 0;
        got_aw.delete(); got_w.delete(); got_ar.delete(); pend_b.delete();
        b_fire = 0; r_fire = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
        continue;
      end
      if (b_fire) bus.m_axil_bvalid = 0;
      if (r_fire) bus.m_axil_rvalid = 0;
      if (!bus.m_axil_bvalid && pend_b.size() > 0 && !b_hold && $urandom_range(0, 99) < rdy_pct) begin
        bus.m_axil_bresp  = pend_b.pop_front();
        bus.m_axil_bvalid = 1;
      end
      if (!bus.m_axil_rvalid && got_ar.size() > 0 && $urandom_range(0, 99) < rdy_pct) begin
        a = got_ar.pop_front();
        bus.m_axil_rdata  = slv_rd(a);
        bus.m_axil_rresp  = slv_resp(a);
        bus.m_axil_rvalid = 1;
      end
      b_fire = bus.m_axil_bvalid && bus.m_axil_bready;
      r_fire = bus.m_axil_rvalid && bus.m_axil_rready;

      if (aw_wait) chk("awvalid_held", 128'(bus.m_axil_awvalid), 128'(1));
      if (w_wait)  chk("wvalid_held",  128'(bus.m_axil_wvalid),  128'(1));
      if (ar_wait) chk("arvalid_held", 128'(bus.m_axil_arvalid), 128'(1));
      bus.m_axil_awready = bus.m_axil_awvalid && ($urandom_range(0, 99) < rdy_pct);
      bus.m_axil_wready  = bus.m_axil_wvalid  && ($urandom_range(0, 99) < rdy_pct);
      bus.m_axil_arready = bus.m_axil_arvalid && ($urandom_range(0, 99) < rdy_pct);
      aw_wait = bus.m_axil_awvalid && !bus.m_axil_awready;
      w_wait  = bus.m_axil_wvalid  && !bus.m_axil_wready;
      ar_wait = bus.m_axil_arvalid && !bus.m_axil_arready;

      if (bus.m_axil_awready) begin
        if (exp_aw.size() == 0) fail_now("aw_unexpected");
        else chk("aw_addr", 128'(bus.m_axil_awaddr), 128'(exp_aw.pop_front()));
        chk("aw_prot", 128'(bus.m_axil_awprot), 128'(0));
        got_aw.push_back(bus.m_axil_awaddr);
      end
      if (bus.m_axil_wready) begin
        last_w = {bus.m_axil_wdata, bus.m_axil_wstrb};
        if (exp_w.size() == 0) fail_now("w_unexpected");
        else chk("w_data_strb", 128'(last_w), 128'(exp_w.pop_front()));
        got_w.push_back(last_w);
      end
      if (bus.m_axil_arready) begin
        if (exp_ar.size() == 0) fail_now("ar_unexpected");
        else chk("ar_addr", 128'(bus.m_axil_araddr), 128'(exp_ar.pop_front()));
        chk("ar_prot", 128'(bus.m_axil_arprot), 128'(0));
        got_ar.push_back(bus.m_axil_araddr);
      end
      while (got_aw.size() > 0 && got_w.size() > 0) begin
        a  = got_aw.pop_front();
        wd = got_w.pop_front();
        m  = slv_rd(a);
        for (int i = 0; i < 4; i++) if (wd[i]) m[8*i +: 8] = wd[4 + 8*i +: 8];
        slv_mem[a] = m;
        pend_b.push_back(slv_resp(a));
      end
    end
  end

  // ---------------- response monitor ----------------
  int          yumi_max = 0;
  logic [63:0] last_resp_data;

  initial begin
    bit   held;
    int   hold;
    msg_s held_msg;
    resp_exp_s e;
    held = 0; hold = 0;
    bus.io_resp_yumi = 0;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        bus.io_resp_yumi = 0;
        held = 0;
        continue;
      end
      if (bus.io_resp_yumi) begin
        bus.io_resp_yumi = 0;
        held = 0;
      end
      if (bus.io_resp_v) begin
        if (held) chk("resp_stable", 128'(bus.io_resp), 128'(held_msg));
        else begin
          held     = 1;
          held_msg = msg_s'(bus.io_resp);
          hold     = $urandom_range(0, yumi_max);
        end
        if (hold == 0) begin
          bus.io_resp_yumi = 1;
          last_resp_data   = held_msg.data;
          if (exp_resp.size() == 0) fail_now("resp_unexpected");
          else begin
            e = exp_resp.pop_front();
            chk("resp_msg", 128'(bus.io_resp), 128'(e.msg));
            chk("resp_error_o", 128'(error_o), 128'(e.err));
          end
        end else hold--;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [3:0] t, input logic [2:0] sz, input logic [31:0] a,
                       input logic [63:0] d);
    msg_s m;
    int   n;
    m          = '0;
    m.msg_type = t;
    m.size     = sz;
    m.addr     = {8'h00, a};
    m.data     = d;
    @(negedge clk);
    bus.io_cmd   = m;
    bus.io_cmd_v = 1;
    n = 0;
    while (!bus.io_cmd_ready_and && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      fail_now("cmd_accept_timeout");
      bus.io_cmd_v = 0;
      return;
    end
    model_cmd(m);
    @(posedge clk);
    #1;
    bus.io_cmd_v = 0;
    bus.io_cmd   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_resp.size() > 0 || !bus.io_cmd_ready_and) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) fail_now("drain_timeout");
  endtask

  task automatic chk_idle_outputs(input string name);
    chk(name, 128'({bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_arvalid,
                    bus.m_axil_bready, bus.m_axil_rready, bus.io_resp_v,
                    bus.io_cmd_ready_and, error_o}), 128'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [3:0]  t;
    logic [2:0]  sz;
    logic [31:0] a, hi;
    int          r;
    exp_err      = 0;
    bus.io_cmd   = '0;
    bus.io_cmd_v = 0;

    #1 chk_idle_outputs("reset_outputs");
    repeat (3) @(negedge clk);
    #2 reset_i = 0;
    @(negedge clk);
    chk("ready_after_reset", 128'(bus.io_cmd_ready_and), 128'(1));
    chk("error_after_reset", 128'(error_o), 128'(0));

    // zero-wait 4B read latency: accept, arvalid, rvalid, io_resp_v on consecutive cycles
    rdy_pct = 100; yumi_max = 0;
    issue(UC_RD, 3'd2, 32'h1000_0010, 64'h0);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bus.io_resp_v) break;
    end
    chk("rd_latency", 128'(n), 128'(3));
    drain();

    yumi_max = 5;
    issue(UC_WR, 3'd2, 32'h1000_0004, 64'hDEAD_BEEF);
    drain();
    chk("w_4b", 128'(last_w), 128'({32'hDEAD_BEEF, 4'hF}));
    issue(UC_WR, 3'd0, 32'h1000_0003, 64'h5A);
    drain();
    chk("w_1b", 128'(last_w), 128'({32'h5A5A_5A5A, 4'b1000}));
    issue(UC_WR, 3'd1, 32'h1000_0002, 64'hBEEF);
    drain();
    chk("w_2b", 128'(last_w), 128'({32'hBEEF_BEEF, 4'b1100}));

    ref_mem[32'h2000] = 32'h1111_1111; slv_mem[32'h2000] = 32'h1111_1111;
    ref_mem[32'h2004] = 32'h2222_2222; slv_mem[32'h2004] = 32'h2222_2222;
    rdy_pct = 50;
    issue(UC_RD, 3'd3, 32'h0000_2000, 64'h0);
    drain();
    chk("rd_8b", 128'(last_resp_data), 128'(64'h2222_2222_1111_1111));

    issue(UC_RD, 3'd2, 32'h1000_0004, 64'h0);
    drain();
    chk("rd_back", 128'(last_resp_data), 128'(64'hDEAD_BEEF));

    issue(UC_RD, 3'd2, 32'hE000_0000, 64'h0);
    drain();
    chk("slverr_sticky", 128'(error_o), 128'(1));
    issue(UC_WR, 3'd3, 32'h1000_0008, 64'h0123_4567_89AB_CDEF);
    issue(UC_RD, 3'd3, 32'h1000_0008, 64'h0);
    drain();
    chk("rd_8b_back", 128'(last_resp_data), 128'(64'h0123_4567_89AB_CDEF));
    issue(UC_RD, 3'd5, 32'h1000_0000, 64'h0);
    drain();

    // reset while waiting in the write-response phase
    b_hold = 1;
    issue(UC_WR, 3'd2, 32'h1000_0020, 64'hCAFE_F00D);
    n = 0;
    while (!bus.m_axil_bready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_bresp", 128'(bus.m_axil_bready), 128'(1));
    @(negedge clk);
    #2 reset_i = 1;
    #1 chk_idle_outputs("midreset_outputs");
    repeat (2) @(negedge clk);
    exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_resp.delete();
    exp_err = 0;
    b_hold  = 0;
    #2 reset_i = 0;
    @(negedge clk);
    chk("ready_after_midreset", 128'(bus.io_cmd_ready_and), 128'(1));
    chk("error_cleared", 128'(error_o), 128'(0));
    issue(UC_RD, 3'd2, 32'h1000_0020, 64'h0);
    drain();
    chk("rd_after_reset", 128'(last_resp_data), 128'(64'hCAFE_F00D));

    for (int i = 0; i < 300; i++) begin
      rdy_pct  = $urandom_range(20, 100);
      yumi_max = $urandom_range(0, 5);
      t  = ($urandom_range(0, 1) == 1) ? UC_WR : UC_RD;
      r  = $urandom_range(0, 19);
      sz = (r == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      r  = $urandom_range(0, 19);
      hi = (i >= 150 && r == 0) ? 32'hE000_0000 : (i >= 150 && r == 1) ? 32'hF000_0000 : 32'h1000_0000;
      a  = hi + 32'($urandom_range(0, 15) * 4);
      if (sz == 3'd0) a = a + 32'($urandom_range(0, 3));
      if (sz == 3'd1) a = a + 32'($urandom_range(0, 1) * 2);
      issue(t, sz, a, {$urandom, $urandom});
    end
    drain();
    repeat (5) @(negedge clk);
    chk("aw_left", 128'(exp_aw.size()), 128'(0));
    chk("w_left",  128'(exp_w.size()),  128'(0));
    chk("ar_left", 128'(exp_ar.size()), 128'(0));
    chk("b_left",  128'(pend_b.size() + int'(bus.m_axil_bvalid)), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
